// File: rtl/uart_frame_parser.sv
// Sync-hunting, length-prefixed, checksummed frame decoder behind a UART receiver.
// Latency: rx_done rise to byte consumption is 3 clk edges; frame_valid rises on the CHK-consuming edge; rd_data 1 cycle.
// Backpressure: none on rx; a held frame blocks parsing until frame_ack, later bytes are dropped with overrun.
module uart_frame_parser #(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         MAX_LEN        = 16,
    parameter int         TIMEOUT_CYCLES = 100000,
    localparam int        LW             = $clog2(MAX_LEN + 1),
    localparam int        AW             = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [7:0]    rx_data,
    input  logic          rx_done,
    input  logic          frame_ack,
    input  logic [AW-1:0] rd_addr,
    output logic [7:0]    rd_data,
    output logic          frame_valid,
    output logic [LW-1:0] frame_len,
    output logic          err_chk,
    output logic          err_len,
    output logic          err_timeout,
    output logic          overrun
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [2:0] {
        HUNT     = 3'd0,
        GET_LEN  = 3'd1,
        GET_DATA = 3'd2,
        GET_CHK  = 3'd3,
        HOLD     = 3'd4
    } state_t;

    state_t          state_q, state_nxt;
    logic [1:0]      rx_sync;
    logic            rx_prev;
    logic            byte_stb;
    logic [LW-1:0]   len_q;
    logic [LW-1:0]   idx_q;
    logic [7:0]      sum_q;
    logic [TW-1:0]   tmo_cnt;
    logic            active;
    logic            timeout_hit;
    logic            len_ok;
    logic            last_byte;
    logic            err_chk_nxt, err_len_nxt, err_tmo_nxt, overrun_nxt;
    logic [7:0]      mem [0:MAX_LEN-1];

    // Synchronizer and edge-detect flops start high so a level held through reset is not a byte.
    assign byte_stb    = rx_sync[1] & ~rx_prev;
    assign active      = (state_q == GET_LEN) || (state_q == GET_DATA) || (state_q == GET_CHK);
    assign timeout_hit = active && !byte_stb && (tmo_cnt == TW'(TIMEOUT_CYCLES));
    assign len_ok      = (rx_data != 8'd0) && (32'(rx_data) <= MAX_LEN);
    assign last_byte   = ((idx_q + LW'(1)) == len_q);

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= HUNT;
        else       state_q <= state_nxt;
    end

    // Next-state decode and one-cycle error pulse requests; a strobe always beats a timeout.
    always_comb begin
        state_nxt   = state_q;
        err_chk_nxt = 1'b0;
        err_len_nxt = 1'b0;
        err_tmo_nxt = 1'b0;
        overrun_nxt = 1'b0;
        case (state_q)
            HUNT: begin
                if (byte_stb && rx_data == SYNC_BYTE) state_nxt = GET_LEN;
            end
            GET_LEN: begin
                if (byte_stb) begin
                    if (len_ok) begin
                        state_nxt = GET_DATA;
                    end else begin
                        err_len_nxt = 1'b1;
                        state_nxt   = HUNT;
                    end
                end else if (timeout_hit) begin
                    err_tmo_nxt = 1'b1;
                    state_nxt   = HUNT;
                end
            end
            GET_DATA: begin
                if (byte_stb) begin
                    if (last_byte) state_nxt = GET_CHK;
                end else if (timeout_hit) begin
                    err_tmo_nxt = 1'b1;
                    state_nxt   = HUNT;
                end
            end
            GET_CHK: begin
                if (byte_stb) begin
                    if (rx_data == sum_q) begin
                        state_nxt = HOLD;
                    end else begin
                        err_chk_nxt = 1'b1;
                        state_nxt   = HUNT;
                    end
                end else if (timeout_hit) begin
                    err_tmo_nxt = 1'b1;
                    state_nxt   = HUNT;
                end
            end
            HOLD: begin
                if (byte_stb)  overrun_nxt = 1'b1;
                if (frame_ack) state_nxt   = HUNT;
            end
            default: state_nxt = HUNT;
        endcase
    end

    // Byte strobe pipeline, frame bookkeeping, timeout counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rx_sync     <= 2'b11;
            rx_prev     <= 1'b1;
            len_q       <= '0;
            idx_q       <= '0;
            sum_q       <= 8'd0;
            tmo_cnt     <= '0;
            frame_valid <= 1'b0;
            frame_len   <= '0;
            err_chk     <= 1'b0;
            err_len     <= 1'b0;
            err_timeout <= 1'b0;
            overrun     <= 1'b0;
            rd_data     <= 8'd0;
        end else begin
            rx_sync     <= {rx_sync[0], rx_done};
            rx_prev     <= rx_sync[1];
            err_chk     <= err_chk_nxt;
            err_len     <= err_len_nxt;
            err_timeout <= err_tmo_nxt;
            overrun     <= overrun_nxt;
            frame_valid <= (state_nxt == HOLD);
            if (!active || byte_stb || state_nxt != state_q) tmo_cnt <= '0;
            else                                             tmo_cnt <= tmo_cnt + TW'(1);
            if (byte_stb) begin
                case (state_q)
                    GET_LEN: begin
                        len_q <= rx_data[LW-1:0];
                        sum_q <= rx_data;
                        idx_q <= '0;
                    end
                    GET_DATA: begin
                        sum_q <= sum_q + rx_data;
                        idx_q <= idx_q + LW'(1);
                    end
                    GET_CHK: begin
                        if (state_nxt == HOLD) frame_len <= len_q;
                    end
                    default: ;
                endcase
            end
            if (32'(rd_addr) < MAX_LEN) rd_data <= mem[rd_addr];
            else                        rd_data <= 8'd0;
        end
    end

    // Payload buffer write; contents are only meaningful while frame_valid is high.
    always_ff @(posedge clk) begin
        if (byte_stb && state_q == GET_DATA) mem[idx_q[AW-1:0]] <= rx_data;
    end

endmodule

// File: tb/tb_uart_frame_parser.sv
// Directed bench for uart_frame_parser with hand-computed frames and checksums.
// Timeout shortened to keep the run small; pulses are counted by a monitor.
// Every comparison is an immediate assertion; a summary line ends the run.
module tb_uart_frame_parser;

    localparam int TMO = 200;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'd0;
    logic       rx_done = 1'b0;
    logic       frame_ack = 1'b0;
    logic [3:0] rd_addr = 4'd0;
    logic [7:0] rd_data;
    logic       frame_valid;
    logic [4:0] frame_len;
    logic       err_chk, err_len, err_timeout, overrun;

    int checks = 0;
    int errors = 0;
    int n_chk = 0, n_len = 0, n_tmo = 0, n_ovr = 0;

    uart_frame_parser #(
        .SYNC_BYTE      (8'hA5),
        .MAX_LEN        (16),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .rx_data     (rx_data),
        .rx_done     (rx_done),
        .frame_ack   (frame_ack),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .frame_valid (frame_valid),
        .frame_len   (frame_len),
        .err_chk     (err_chk),
        .err_len     (err_len),
        .err_timeout (err_timeout),
        .overrun     (overrun)
    );

    always #5 clk = ~clk;

    // Count high cycles of each pulse output just after every rising edge.
    always begin
        @(posedge clk);
        #1;
        if (err_chk)     n_chk++;
        if (err_len)     n_len++;
        if (err_timeout) n_tmo++;
        if (overrun)     n_ovr++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] b);
        @(negedge clk);
        rx_data = b;
        rx_done = 1'b1;
        repeat (4) @(negedge clk);
        rx_done = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic rd(input string tag, input logic [3:0] a, input logic [7:0] exp);
        @(negedge clk);
        rd_addr = a;
        @(negedge clk);
        chk(tag, {24'd0, rd_data}, {24'd0, exp});
    endtask

    task automatic ack(input string tag);
        @(negedge clk);
        frame_ack = 1'b1;
        @(negedge clk);
        frame_ack = 1'b0;
        chk(tag, {31'd0, frame_valid}, 32'd0);
    endtask

    task automatic chk_errs(input string tag, input int c, input int l, input int t, input int o);
        chk({tag, "_chk"}, n_chk, c);
        chk({tag, "_len"}, n_len, l);
        chk({tag, "_tmo"}, n_tmo, t);
        chk({tag, "_ovr"}, n_ovr, o);
    endtask

    initial begin
        // Reset state, with rx_done low.
        repeat (3) @(negedge clk);
        chk("reset_outs", {rd_data, frame_valid, frame_len, err_chk, err_len, err_timeout, overrun}, 32'd0);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        chk("idle_valid", {31'd0, frame_valid}, 32'd0);

        // Good frame: 03 + 11 + 22 + 33 = 69.
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h69);
        chk("a_valid", {31'd0, frame_valid}, 32'd1);
        chk("a_len", {27'd0, frame_len}, 32'd3);
        rd("a_rd0", 4'd0, 8'h11);
        rd("a_rd1", 4'd1, 8'h22);
        rd("a_rd2", 4'd2, 8'h33);
        chk_errs("a", 0, 0, 0, 0);
        ack("a_ack");

        // Bad checksum, then A5 01 FF 00 (01 + FF wraps to 00).
        send(8'hA5); send(8'h03); send(8'h11); send(8'h22); send(8'h33); send(8'h68);
        chk("b_valid", {31'd0, frame_valid}, 32'd0);
        chk_errs("b", 1, 0, 0, 0);
        send(8'hA5); send(8'h01); send(8'hFF); send(8'h00);
        chk("c_valid", {31'd0, frame_valid}, 32'd1);
        chk("c_len", {27'd0, frame_len}, 32'd1);
        rd("c_rd0", 4'd0, 8'hFF);
        ack("c_ack");

        // Length zero and length 17.
        send(8'hA5); send(8'h00);
        chk("len0", n_len, 1);
        send(8'hA5); send(8'h11);
        chk("len17", n_len, 2);
        chk("len_valid", {31'd0, frame_valid}, 32'd0);

        // Leading garbage, payload containing the sync value: 02 + A5 + A5 = 14C.
        send(8'h00); send(8'h5A); send(8'hA5); send(8'h02); send(8'hA5); send(8'hA5); send(8'h4C);
        chk("g_valid", {31'd0, frame_valid}, 32'd1);
        chk("g_len", {27'd0, frame_len}, 32'd2);
        rd("g_rd0", 4'd0, 8'hA5);
        rd("g_rd1", 4'd1, 8'hA5);
        chk_errs("g", 1, 2, 0, 0);
        ack("g_ack");

        // Stall mid-payload: no pulse before the limit, exactly one after.
        send(8'hA5); send(8'h02); send(8'h10);
        repeat (TMO - 30) @(negedge clk);
        chk("tmo_early", n_tmo, 0);
        repeat (60) @(negedge clk);
        chk("tmo_fire", n_tmo, 1);
        send(8'hA5); send(8'h01); send(8'h07); send(8'h08);
        chk("t_valid", {31'd0, frame_valid}, 32'd1);
        chk("t_len", {27'd0, frame_len}, 32'd1);
        rd("t_rd0", 4'd0, 8'h07);

        // Bytes arriving while the frame is held.
        send(8'h55); send(8'hA5);
        chk("ovr_cnt", n_ovr, 2);
        chk("ovr_valid", {31'd0, frame_valid}, 32'd1);
        chk("ovr_len", {27'd0, frame_len}, 32'd1);
        ack("ovr_ack");
        chk_errs("o", 1, 2, 1, 2);

        // Reset in the middle of a payload.
        send(8'hA5); send(8'h04); send(8'h01); send(8'h02);
        rd("pre_rst_rd0", 4'd0, 8'h01);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("mid_rst_outs", {rd_data, frame_valid, frame_len, err_chk, err_len, err_timeout, overrun}, 32'd0);
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        // 02 + 30 + 40 = 72.
        send(8'hA5); send(8'h02); send(8'h30); send(8'h40); send(8'h72);
        chk("r_valid", {31'd0, frame_valid}, 32'd1);
        chk("r_len", {27'd0, frame_len}, 32'd2);
        rd("r_rd1", 4'd1, 8'h40);
        chk_errs("r", 1, 2, 1, 2);
        ack("r_ack");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
